// File: rtl/fd_pkg.sv
// rtl/fd_pkg.sv - shared types and constants for the FAST-9 raster-scan controller
// Contents:
//   state_t        scan FSM states
//   offset_t       signed (dx,dy) pair of a Bresenham-circle pixel
//   circle_offset  circle index 0..15 -> offset, clockwise from 12 o'clock
//   NUM_CIRCLE, FETCH_CNT, BORDER
package fd_pkg;

  localparam int NUM_CIRCLE = 16;
  localparam int FETCH_CNT  = 17;  // centre + 16 circle pixels
  localparam int BORDER     = 3;   // circle radius, so interior starts 3 from each edge

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LAST,
    EVAL,
    OUT,
    DONE
  } state_t;

  typedef struct packed {
    logic signed [2:0] dx;
    logic signed [2:0] dy;
  } offset_t;

  function automatic offset_t circle_offset(input logic [3:0] idx);
    offset_t o;
    case (idx)
      4'd0:    o = '{ 3'sd0, -3'sd3};
      4'd1:    o = '{ 3'sd1, -3'sd3};
      4'd2:    o = '{ 3'sd2, -3'sd2};
      4'd3:    o = '{ 3'sd3, -3'sd1};
      4'd4:    o = '{ 3'sd3,  3'sd0};
      4'd5:    o = '{ 3'sd3,  3'sd1};
      4'd6:    o = '{ 3'sd2,  3'sd2};
      4'd7:    o = '{ 3'sd1,  3'sd3};
      4'd8:    o = '{ 3'sd0,  3'sd3};
      4'd9:    o = '{-3'sd1,  3'sd3};
      4'd10:   o = '{-3'sd2,  3'sd2};
      4'd11:   o = '{-3'sd3,  3'sd1};
      4'd12:   o = '{-3'sd3,  3'sd0};
      4'd13:   o = '{-3'sd3, -3'sd1};
      4'd14:   o = '{-3'sd2, -3'sd2};
      default: o = '{-3'sd1, -3'sd3};
    endcase
    return o;
  endfunction

endpackage

// File: rtl/FD_Datapath.sv
// rtl/FD_Datapath.sv - combinational FAST-9 corner test on one centre pixel and its 16-pixel circle
// Ports:
//   refPixel  in  8    centre pixel
//   adjPixel  in  128  circle pixel i at [127-8i -: 8]
//   thres     in  8    threshold; bounds are saturated to 0..255 here
//   isCorner  out 1    9 or more contiguous circle pixels all brighter or all darker
module FD_Datapath (
  input  logic [7:0]   refPixel,
  input  logic [127:0] adjPixel,
  input  logic [7:0]   thres,
  output logic         isCorner
);

  logic [8:0]  hi_sum;
  logic [7:0]  hi_lim;
  logic [7:0]  lo_lim;
  logic [15:0] bright;
  logic [15:0] dark;
  logic        run_b;
  logic        run_d;
  logic [3:0]  idx;

  always_comb begin
    hi_sum = {1'b0, refPixel} + {1'b0, thres};
    hi_lim = hi_sum[8] ? 8'hFF : hi_sum[7:0];
    lo_lim = (refPixel > thres) ? (refPixel - thres) : 8'h00;

    for (int i = 0; i < 16; i++) begin
      bright[i] = adjPixel[127-8*i -: 8] > hi_lim;
      dark[i]   = adjPixel[127-8*i -: 8] < lo_lim;
    end

    // Try every start position; the arc may wrap past pixel 15 back to 0.
    isCorner = 1'b0;
    run_b    = 1'b0;
    run_d    = 1'b0;
    idx      = 4'd0;
    for (int s = 0; s < 16; s++) begin
      run_b = 1'b1;
      run_d = 1'b1;
      for (int j = 0; j < 9; j++) begin
        idx   = 4'(s + j);
        run_b = run_b & bright[idx];
        run_d = run_d & dark[idx];
      end
      isCorner = isCorner | run_b | run_d;
    end
  end

endmodule

// File: rtl/fd_addr_gen.sv
// rtl/fd_addr_gen.sv - pixel-memory address for fetch index k around the current scan position
// Ports:
//   x, y  in   COORD_W  current scan coordinate (always interior)
//   k     in   5        fetch index: 0 = centre, 1..16 = circle pixel k-1
//   addr  out  ADDR_W   (y+dy)*IMG_W + (x+dx)
module fd_addr_gen
  import fd_pkg::*;
#(
  parameter int IMG_W   = 64,
  parameter int ADDR_W  = 12,
  parameter int COORD_W = 8
) (
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [4:0]         k,
  output logic [ADDR_W-1:0]  addr
);

  offset_t            off;
  logic [COORD_W+1:0] px;
  logic [COORD_W+1:0] py;

  always_comb begin
    off = '{3'sd0, 3'sd0};
    if (k != 5'd0) begin
      off = circle_offset(4'(k - 5'd1));
    end
    // Two's-complement add of the sign-extended offset; interior scanning keeps
    // the result non-negative, so it can be treated as unsigned afterwards.
    px   = {2'b00, x} + {{(COORD_W-1){off.dx[2]}}, off.dx};
    py   = {2'b00, y} + {{(COORD_W-1){off.dy[2]}}, off.dy};
    addr = ADDR_W'(py) * ADDR_W'(IMG_W) + ADDR_W'(px);
  end

endmodule

// File: rtl/fd_scan_ctrl.sv
// rtl/fd_scan_ctrl.sv - raster-scan sequencer feeding FD_Datapath and emitting one corner result per pixel
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   start, thres         frame start pulse, threshold latched at start
//   memRd, memAddr       pixel read strobe/address (read data one cycle later)
//   memData              pixel read data
//   outValid, outReady   result stream handshake
//   outCorner, outX, outY  result payload, held while outValid && !outReady
//   busy, done           scan in progress, one-cycle end-of-frame pulse
module fd_scan_ctrl
  import fd_pkg::*;
#(
  parameter int IMG_W   = 64,
  parameter int IMG_H   = 48,
  parameter int ADDR_W  = 12,
  parameter int COORD_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [7:0]         thres,
  output logic               memRd,
  output logic [ADDR_W-1:0]  memAddr,
  input  logic [7:0]         memData,
  output logic               outValid,
  input  logic               outReady,
  output logic               outCorner,
  output logic [COORD_W-1:0] outX,
  output logic [COORD_W-1:0] outY,
  output logic               busy,
  output logic               done
);

  if (IMG_W < 7) begin : g_chk_w
    $error("fd_scan_ctrl: IMG_W must be >= 7");
  end
  if (IMG_H < 7) begin : g_chk_h
    $error("fd_scan_ctrl: IMG_H must be >= 7");
  end
  if ($clog2(IMG_W * IMG_H) > ADDR_W) begin : g_chk_a
    $error("fd_scan_ctrl: ADDR_W too small for IMG_W*IMG_H");
  end
  if ((1 << COORD_W) < IMG_W || (1 << COORD_W) < IMG_H) begin : g_chk_c
    $error("fd_scan_ctrl: COORD_W too small for frame size");
  end

  localparam logic [COORD_W-1:0] X_FIRST = COORD_W'(BORDER);
  localparam logic [COORD_W-1:0] X_LAST  = COORD_W'(IMG_W - 1 - BORDER);
  localparam logic [COORD_W-1:0] Y_LAST  = COORD_W'(IMG_H - 1 - BORDER);
  localparam logic [4:0]         K_LAST  = 5'(FETCH_CNT - 1);

  state_t             state_q, state_d;
  logic [4:0]         k_q, k_d;
  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic [7:0]         thres_q, thres_d;
  logic [7:0]         ref_q, ref_d;
  logic [127:0]       adj_q, adj_d;
  logic               out_valid_q, out_valid_d;
  logic               out_corner_q, out_corner_d;
  logic [COORD_W-1:0] out_x_q, out_x_d;
  logic [COORD_W-1:0] out_y_q, out_y_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               is_corner;
  logic [ADDR_W-1:0]  fetch_addr;
  logic               last_px;
  logic               cap_en;
  logic [4:0]         cap_idx;

  fd_addr_gen #(
    .IMG_W   (IMG_W),
    .ADDR_W  (ADDR_W),
    .COORD_W (COORD_W)
  ) u_addr_gen (
    .x    (x_q),
    .y    (y_q),
    .k    (k_q),
    .addr (fetch_addr)
  );

  FD_Datapath u_datapath (
    .refPixel (ref_q),
    .adjPixel (adj_q),
    .thres    (thres_q),
    .isCorner (is_corner)
  );

  // Read strobe and address decode straight from registered state, so a
  // reset leaves them at zero on the very next cycle.
  assign memRd   = (state_q == FETCH);
  assign memAddr = memRd ? fetch_addr : '0;

  assign last_px = (x_q == X_LAST) && (y_q == Y_LAST);

  // Data for index k-1 arrives while k is current. k reaches 17 in LAST, so
  // the same k-1 rule captures the final circle pixel there.
  assign cap_en  = ((state_q == FETCH) && (k_q != 5'd0)) || (state_q == LAST);
  assign cap_idx = k_q - 5'd1;

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    x_d          = x_q;
    y_d          = y_q;
    thres_d      = thres_q;
    ref_d        = ref_q;
    adj_d        = adj_q;
    out_valid_d  = out_valid_q;
    out_corner_d = out_corner_q;
    out_x_d      = out_x_q;
    out_y_d      = out_y_q;
    busy_d       = busy_q;
    done_d       = done_q;

    if (cap_en) begin
      if (cap_idx == 5'd0) begin
        ref_d = memData;
      end
      for (int i = 0; i < NUM_CIRCLE; i++) begin
        if (cap_idx == 5'(i + 1)) begin
          adj_d[127-8*i -: 8] = memData;
        end
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          thres_d = thres;
          x_d     = X_FIRST;
          y_d     = X_FIRST;
          k_d     = 5'd0;
          busy_d  = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: begin
        k_d = k_q + 5'd1;
        if (k_q == K_LAST) begin
          state_d = LAST;
        end
      end
      LAST: begin
        state_d = EVAL;
      end
      EVAL: begin
        out_corner_d = is_corner;
        out_x_d      = x_q;
        out_y_d      = y_q;
        out_valid_d  = 1'b1;
        state_d      = OUT;
      end
      OUT: begin
        if (outReady) begin
          out_valid_d = 1'b0;
          if (last_px) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            k_d     = 5'd0;
            state_d = FETCH;
            if (x_q == X_LAST) begin
              x_d = X_FIRST;
              y_d = y_q + 1'b1;
            end else begin
              x_d = x_q + 1'b1;
            end
          end
        end
      end
      DONE: begin
        done_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      k_q          <= '0;
      x_q          <= '0;
      y_q          <= '0;
      thres_q      <= '0;
      ref_q        <= '0;
      adj_q        <= '0;
      out_valid_q  <= 1'b0;
      out_corner_q <= 1'b0;
      out_x_q      <= '0;
      out_y_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      x_q          <= x_d;
      y_q          <= y_d;
      thres_q      <= thres_d;
      ref_q        <= ref_d;
      adj_q        <= adj_d;
      out_valid_q  <= out_valid_d;
      out_corner_q <= out_corner_d;
      out_x_q      <= out_x_d;
      out_y_q      <= out_y_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign outValid  = out_valid_q;
  assign outCorner = out_corner_q;
  assign outX      = out_x_q;
  assign outY      = out_y_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
